// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_e;

   // Failure reasons reported on err_code.
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
   localparam logic [1:0] ERR_CHECKSUM = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and pulses
// expired_c combinationally on the cycle the count would reach TIMEOUT.
module loader_timeout #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count; a clear (byte transfer) in the final cycle wins over expiry.
   always_comb begin
      cnt_d     = cnt_q;
      expired_c = 1'b0;
      if (!enable || clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         expired_c = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: receives length, payload and checksum, writes
// the payload into RAM and releases the core from reset on a good frame.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_adress,
   output logic [DATA_W-1:0] data_in,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              xfer;
   logic              tmo_enable;
   logic              tmo_expired_c;
   logic [DATA_W-1:0] chk_sum;

   // A byte moves only when the registered ready is high.
   assign xfer       = in_valid && in_ready_q;
   assign tmo_enable = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
   assign chk_sum    = sum_q + in_data;

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .enable    (tmo_enable),
      .clear     (xfer),
      .expired_c (tmo_expired_c)
   );

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sum_d      = sum_q;
      rem_d      = rem_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_code_d = err_code_q;

      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d    = LEN;
               sum_d      = '0;
               addr_d     = ADDR_W'(BASE_ADDR);
               err_code_d = ERR_NONE;
            end
         end
         LEN: begin
            if (xfer) begin
               if (in_data == '0) begin
                  state_d    = ERROR;
                  err_code_d = ERR_ZERO_LEN;
               end else begin
                  rem_d   = in_data;
                  state_d = DATA;
               end
            end else if (tmo_expired_c) begin
               state_d    = ERROR;
               err_code_d = ERR_TIMEOUT;
            end
         end
         DATA: begin
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = in_data;
               addr_d    = addr_q + ADDR_W'(1);
               sum_d     = chk_sum;
               rem_d     = rem_q - DATA_W'(1);
               if (rem_q == DATA_W'(1)) state_d = CHECK;
            end else if (tmo_expired_c) begin
               state_d    = ERROR;
               err_code_d = ERR_TIMEOUT;
            end
         end
         CHECK: begin
            if (xfer) begin
               if (chk_sum == '0) begin
                  state_d = DONE;
               end else begin
                  state_d    = ERROR;
                  err_code_d = ERR_CHECKSUM;
               end
            end else if (tmo_expired_c) begin
               state_d    = ERROR;
               err_code_d = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags follow the state being entered so they line up with it.
      in_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHECK);
      busy_d     = in_ready_d;
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERROR);
      cpu_rst_d  = (state_d != DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sum_q      <= '0;
         rem_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_rst_q  <= 1'b1;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sum_q      <= sum_d;
         rem_q      <= rem_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_rst_q  <= cpu_rst_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign write_en     = wr_en_q;
   assign write_adress = wr_addr_q;
   assign data_in      = wr_data_q;
   assign cpu_rst      = cpu_rst_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 00 and base FE, timeout 8)
// share one input stream; a vector table plus hand-written corner sequences.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;

   logic       rdy0, we0, crst0, bsy0, dn0, er0;
   logic [7:0] wa0, wd0;
   logic [1:0] ec0;
   logic       rdy1, we1, crst1, bsy1, dn1, er1;
   logic [7:0] wa1, wd1;
   logic [1:0] ec1;

   int checks = 0;
   int errors = 0;

   program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0), .TIMEOUT(8)) u0 (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .write_en(we0), .write_adress(wa0), .data_in(wd0),
      .cpu_rst(crst0), .busy(bsy0), .done(dn0), .error(er0), .err_code(ec0));

   program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE), .TIMEOUT(8)) u1 (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .write_en(we1), .write_adress(wa1), .data_in(wd1),
      .cpu_rst(crst1), .busy(bsy1), .done(dn1), .error(er1), .err_code(ec1));

   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       vl;
      logic [7:0] d;
      logic       rdy;
      logic       we;
      logic [7:0] wa0;
      logic [7:0] wa1;
      logic [7:0] wd;
      logic       crst;
      logic       bsy;
      logic       dn;
      logic       er;
      logic [1:0] ec;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] d,
                               input logic rdy, input logic we, input logic [7:0] a0,
                               input logic [7:0] a1, input logic [7:0] wd,
                               input logic crst, input logic bsy, input logic dn,
                               input logic er, input logic [1:0] ec);
      vec_t v;
      v.st = st; v.vl = vl; v.d = d; v.rdy = rdy; v.we = we; v.wa0 = a0; v.wa1 = a1;
      v.wd = wd; v.crst = crst; v.bsy = bsy; v.dn = dn; v.er = er; v.ec = ec;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Status of instance u0.
   task automatic chk_st(input string n, input logic rdy, input logic bsy, input logic crst,
                         input logic dn, input logic er, input logic [1:0] ec);
      chk1({n, " in_ready"}, rdy0, rdy);
      chk1({n, " busy"}, bsy0, bsy);
      chk1({n, " cpu_rst"}, crst0, crst);
      chk1({n, " done"}, dn0, dn);
      chk1({n, " error"}, er0, er);
      chk8({n, " err_code"}, {6'd0, ec0}, {6'd0, ec});
   endtask

   // Write port of instance u0.
   task automatic chk_wr(input string n, input logic we, input logic [7:0] a, input logic [7:0] d);
      chk1({n, " write_en"}, we0, we);
      if (we) begin
         chk8({n, " write_adress"}, wa0, a);
         chk8({n, " data_in"}, wd0, d);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d);
      start = s; in_valid = v; in_data = d;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick(); tick();
      chk_st("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      chk_wr("reset", 1'b0, 8'h00, 8'h00);
      chk8("reset write_adress", wa0, 8'h00);
      chk8("reset data_in", wd0, 8'h00);
      rst = 1'b0;
      tick();
      chk_st("post-reset idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Good frame; start coincides with valid (no byte consumed); valid while not ready.
      vecs.push_back(mk(1,1,8'h03, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h03, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h11, 1,1,8'h00,8'hFE,8'h11, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h22, 1,1,8'h01,8'hFF,8'h22, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h33, 1,1,8'h02,8'h00,8'h33, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h9A, 0,0,8'h00,8'h00,8'h00, 0,0,1,0,2'd0));
      vecs.push_back(mk(0,1,8'h55, 0,0,8'h00,8'h00,8'h00, 0,0,1,0,2'd0));
      // Frame 03,01,02,03,FA: u1 wraps FE,FF,00.
      vecs.push_back(mk(1,0,8'h00, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h03, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h01, 1,1,8'h00,8'hFE,8'h01, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h02, 1,1,8'h01,8'hFF,8'h02, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h03, 1,1,8'h02,8'h00,8'h03, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'hFA, 0,0,8'h00,8'h00,8'h00, 0,0,1,0,2'd0));
      // Checksum mismatch (00 instead of D0).
      vecs.push_back(mk(1,0,8'h00, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h02, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h10, 1,1,8'h00,8'hFE,8'h10, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h20, 1,1,8'h01,8'hFF,8'h20, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h00, 0,0,8'h00,8'h00,8'h00, 1,0,0,1,2'd2));
      vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,8'h00,8'h00, 1,0,0,1,2'd2));
      // Recovery with a valid frame 01,05,FB.
      vecs.push_back(mk(1,0,8'h00, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h01, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h05, 1,1,8'h00,8'hFE,8'h05, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'hFB, 0,0,8'h00,8'h00,8'h00, 0,0,1,0,2'd0));
      // Zero length.
      vecs.push_back(mk(1,0,8'h00, 1,0,8'h00,8'h00,8'h00, 1,1,0,0,2'd0));
      vecs.push_back(mk(0,1,8'h00, 0,0,8'h00,8'h00,8'h00, 1,0,0,1,2'd1));
      vecs.push_back(mk(0,0,8'h00, 0,0,8'h00,8'h00,8'h00, 1,0,0,1,2'd1));

      foreach (vecs[i]) begin
         string n;
         n = $sformatf("v%0d", i);
         drive(vecs[i].st, vecs[i].vl, vecs[i].d);
         chk_st(n, vecs[i].rdy, vecs[i].bsy, vecs[i].crst, vecs[i].dn, vecs[i].er, vecs[i].ec);
         chk_wr(n, vecs[i].we, vecs[i].wa0, vecs[i].wd);
         chk1({n, " u1 write_en"}, we1, vecs[i].we);
         chk1({n, " u1 done"}, dn1, vecs[i].dn);
         if (vecs[i].we) begin
            chk8({n, " u1 write_adress"}, wa1, vecs[i].wa1);
            chk8({n, " u1 data_in"}, wd1, vecs[i].wd);
         end
      end

      // Timeout: 8 idle cycles in DATA.
      drive(1, 0, 8'h00);
      drive(0, 1, 8'h04);
      drive(0, 1, 8'h01);
      chk_wr("tmo first byte", 1'b1, 8'h00, 8'h01);
      repeat (7) drive(0, 0, 8'h00);
      chk_st("tmo 7 idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      drive(0, 0, 8'h00);
      chk_st("tmo 8 idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);

      // Byte on the 8th idle cycle wins over the timeout.
      drive(1, 0, 8'h00);
      chk_st("tmo2 start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      drive(0, 1, 8'h04);
      drive(0, 1, 8'h01);
      repeat (7) drive(0, 0, 8'h00);
      drive(0, 1, 8'h02);
      chk_wr("tmo2 late byte", 1'b1, 8'h01, 8'h02);
      chk_st("tmo2 late byte", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      drive(0, 1, 8'h03);
      drive(0, 1, 8'h04);
      chk_wr("tmo2 last byte", 1'b1, 8'h03, 8'h04);
      drive(0, 1, 8'hF6);
      chk_st("tmo2 done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // Start during DATA is ignored; async reset mid-frame drops the write pulse.
      drive(1, 0, 8'h00);
      chk1("restart cpu_rst", crst0, 1'b1);
      drive(0, 1, 8'h04);
      drive(0, 1, 8'hAA);
      chk_wr("mid AA", 1'b1, 8'h00, 8'hAA);
      drive(1, 1, 8'hBB);
      chk_wr("mid start ignored", 1'b1, 8'h01, 8'hBB);
      chk_st("mid start ignored", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      start = 1'b0; in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk_st("async rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      chk1("async rst write_en", we0, 1'b0);
      chk8("async rst write_adress", wa0, 8'h00);
      chk8("async rst data_in", wd0, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      chk_st("after rst idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      drive(1, 0, 8'h00);
      drive(0, 1, 8'h02);
      drive(0, 1, 8'h40);
      chk_wr("reload 40", 1'b1, 8'h00, 8'h40);
      drive(0, 1, 8'h50);
      chk_wr("reload 50", 1'b1, 8'h01, 8'h50);
      drive(0, 1, 8'h70);
      chk_st("reload done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      chk1("reload no write", we0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the processor's RAM.
- Accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and writes the payload into the RAM through its write port (write_en, write_adress, data_in).
- Holds the processor core in reset until a frame loads with a valid checksum.
- Runs on the same clk as the core.

Parameters:
- ADDR_W, 8, RAM address width; write address wraps modulo 2^ADDR_W.
- DATA_W, 8, byte width of stream and RAM data.
- BASE_ADDR, 0, RAM address of the first payload byte.
- TIMEOUT, 1000, maximum idle cycles between accepted bytes while a frame is in progress; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a frame; honoured only in IDLE, DONE or ERROR.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- write_en  output  1  RAM write strobe.
- write_adress  output  ADDR_W  RAM write address.
- data_in  output  DATA_W  RAM write data.
- cpu_rst  output  1  reset for the core; high until a successful load.
- busy  output  1  frame in progress.
- done  output  1  last frame loaded correctly; sticky until next start.
- error  output  1  last frame failed; sticky until next start.
- err_code  output  2  00 none, 01 zero length, 10 checksum mismatch, 11 timeout.

Behaviour:
- Reset (async, rst=1): state=IDLE, cpu_rst=1, in_ready=0, write_en=0, write_adress=0, data_in=0, busy=0, done=0, error=0, err_code=00, counters cleared.
- All outputs are registered.
- A byte transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- States: IDLE, LEN, DATA, CHECK, DONE, ERROR.
- IDLE:
  - in_ready=0, busy=0.
  - start → LEN; clear done, error, err_code; sum=0; addr=BASE_ADDR; cpu_rst=1.
- LEN:
  - in_ready=1, busy=1.
  - Transfer of 0 → ERROR with err_code 01.
  - Transfer of L (1..255) → remaining=L, go to DATA.
- DATA:
  - in_ready=1, busy=1.
  - Each transfer: next cycle write_en=1, write_adress=addr, data_in=byte (one-cycle latency, one-cycle strobe).
  - Also on each transfer: addr=addr+1 mod 2^ADDR_W, sum=sum+byte mod 256, remaining decrements.
  - The transfer that brings remaining to 0 → CHECK.
- CHECK:
  - in_ready=1, busy=1.
  - On transfer of byte C: if (sum+C) mod 256 == 0 → DONE, else ERROR with err_code 10.
- DONE:
  - done=1, cpu_rst=0 from the cycle DONE is entered, in_ready=0, busy=0.
  - start → LEN, and cpu_rst returns to 1 on the same edge.
- ERROR:
  - error=1, cpu_rst=1, in_ready=0, busy=0.
  - start → LEN.
  - RAM contents already written are not rolled back.
- Timeout:
  - Idle counter is cleared on every transfer and on entry to LEN.
  - It increments each cycle in LEN, DATA or CHECK without a transfer.
  - Reaching TIMEOUT → ERROR with err_code 11.
  - A transfer in the same cycle the count would reach TIMEOUT wins: byte accepted, counter cleared.
- Boundary rules:
  - start while busy: ignored.
  - start coincident with in_valid in IDLE/DONE/ERROR: only start acts; in_ready is 0 that cycle, so no byte is consumed.
  - Address wrap: BASE_ADDR+L beyond 255 continues from 0, no error.
  - in_valid=1 while in_ready=0: no effect; the source must hold the byte.
  - rst mid-frame: immediate return to the reset values; the write_en pulse in flight is dropped.

Decomposition:
- Package loader_pkg:
  - state encoding: IDLE, LEN, DATA, CHECK, DONE, ERROR
  - err_code constants: ERR_NONE, ERR_ZERO_LEN, ERR_CHECKSUM, ERR_TIMEOUT
- One sub-module, loader_timeout:
  - inputs: clk, rst, enable, clear
  - output: expired pulse
  - parameter: TIMEOUT
- Everything else lives in program_loader.

Test Plan:
- Reset, then start, then bytes 03,11,22,33,9A with in_valid held high → writes 11@00, 22@01, 33@02; each write_en one cycle after its transfer; done=1, cpu_rst falls, err_code=00.
- BASE_ADDR=FE, frame 03,01,02,03,FA → writes at FE, FF, 00; done=1.
- Frame 02,10,20, checksum 00 (expected D0) → error=1, err_code=10, cpu_rst stays 1; then start plus a valid frame → done=1.
- start then length 00 → error=1, err_code=01 the cycle after the transfer, no write_en.
- TIMEOUT=8: start, 04, 01, then in_valid low for 8 cycles → err_code=11. Same run with a byte arriving on the 8th idle cycle → accepted, no error.
- rst asserted mid-DATA, after 2 of 4 bytes → all outputs at reset values asynchronously; a subsequent start plus a full frame loads correctly. A start pulsed during DATA is ignored.
